// File: rtl/timer_alarm.sv
// ---------------------------------------------------------------------------
// timer_alarm
//
// Down-counting alarm timer with one-shot and periodic modes, a sticky
// expiry interrupt and a sticky overrun flag.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-low reset
//   ALARM_ENABLE   in   count-down enable (low freezes count and state)
//   ALARM_MODE     in   0 = one-shot, 1 = periodic (captured on load)
//   ALARM_LOAD     in   single-cycle load/restart strobe
//   ALARM_PERIOD   in   period in enabled cycles (captured on load)
//   ALARM_IRQ_ACK  in   single-cycle acknowledge, clears IRQ and OVERRUN
//   ALARM_IRQ      out  sticky expiry interrupt
//   ALARM_OVERRUN  out  expiry seen while IRQ still pending
//   ALARM_COUNT    out  remaining count
//   ALARM_STATE    out  0 IDLE, 1 RUN, 2 EXPIRED
// ---------------------------------------------------------------------------
module timer_alarm #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ALARM_ENABLE,
    input  logic                  ALARM_MODE,
    input  logic                  ALARM_LOAD,
    input  logic [2*DATA_W-1:0]   ALARM_PERIOD,
    input  logic                  ALARM_IRQ_ACK,
    output logic                  ALARM_IRQ,
    output logic                  ALARM_OVERRUN,
    output logic [2*DATA_W-1:0]   ALARM_COUNT,
    output logic [1:0]            ALARM_STATE
);

    localparam int CW = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   period_q, period_d;
    logic            mode_q, mode_d;
    logic            irq_q, irq_d;
    logic            ovr_q, ovr_d;

    logic            expiry_s;
    logic            period_zero_s;
    logic            count_one_s;

    assign period_zero_s = (ALARM_PERIOD == CNT_ZERO);
    assign count_one_s   = (count_q == CNT_ONE);

    // A load in the same cycle wins over the expiry, so the expiry is masked here.
    assign expiry_s = (state_q == ST_RUN) && ALARM_ENABLE && count_one_s && !ALARM_LOAD;

    // Next-state computation for the counter, latched configuration and FSM.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;

        if (ALARM_LOAD) begin
            if (!period_zero_s) begin
                count_d  = ALARM_PERIOD;
                period_d = ALARM_PERIOD;
                mode_d   = ALARM_MODE;
                state_d  = ST_RUN;
            end else begin
                // Zero period acts as a stop command; configuration is left as it was.
                count_d = CNT_ZERO;
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                ST_RUN: begin
                    if (expiry_s) begin
                        if (mode_q) begin
                            count_d = period_q;
                            state_d = ST_RUN;
                        end else begin
                            count_d = CNT_ZERO;
                            state_d = ST_EXPIRED;
                        end
                    end else if (ALARM_ENABLE && (count_q > CNT_ONE)) begin
                        count_d = count_q - CNT_ONE;
                    end else begin
                        count_d = count_q;
                    end
                end
                default: begin
                    // Unused encoding: fall back to a safe stopped state.
                    count_d = CNT_ZERO;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sticky IRQ/OVERRUN: expiry sets, ACK clears, expiry beats a same-cycle ACK.
    always_comb begin
        irq_d = irq_q;
        ovr_d = ovr_q;
        if (expiry_s) begin
            irq_d = 1'b1;
            if (irq_q && !ALARM_IRQ_ACK) begin
                ovr_d = 1'b1;
            end else if (ALARM_IRQ_ACK) begin
                ovr_d = 1'b0;
            end else begin
                ovr_d = ovr_q;
            end
        end else if (ALARM_IRQ_ACK) begin
            irq_d = 1'b0;
            ovr_d = 1'b0;
        end else begin
            irq_d = irq_q;
            ovr_d = ovr_q;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            count_q  <= CNT_ZERO;
            period_q <= CNT_ZERO;
            mode_q   <= 1'b0;
            irq_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            irq_q    <= irq_d;
            ovr_q    <= ovr_d;
        end
    end

    assign ALARM_IRQ     = irq_q;
    assign ALARM_OVERRUN = ovr_q;
    assign ALARM_COUNT   = count_q;
    assign ALARM_STATE   = state_q;

endmodule

// File: tb/tb_timer_alarm.sv
module tb_timer_alarm;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic        load;
    logic [63:0] period;
    logic        ack;
    logic        irq;
    logic        ovr;
    logic [63:0] count;
    logic [1:0]  state;

    int n_vec;
    int n_miss;

    timer_alarm #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ALARM_ENABLE  (en),
        .ALARM_MODE    (mode),
        .ALARM_LOAD    (load),
        .ALARM_PERIOD  (period),
        .ALARM_IRQ_ACK (ack),
        .ALARM_IRQ     (irq),
        .ALARM_OVERRUN (ovr),
        .ALARM_COUNT   (count),
        .ALARM_STATE   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        l;
        logic [63:0] p;
        logic        m;
        logic        e;
        logic        a;
        logic [63:0] c;
        logic        i;
        logic        o;
        logic [1:0]  s;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic l, input logic [63:0] p, input logic m,
                                input logic e, input logic a, input logic [63:0] c,
                                input logic i, input logic o, input logic [1:0] s);
        vec_t v;
        v.l = l; v.p = p; v.m = m; v.e = e; v.a = a;
        v.c = c; v.i = i; v.o = o; v.s = s;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] c, input logic i,
                       input logic o, input logic [1:0] s);
        n_vec++;
        if (count !== c || irq !== i || ovr !== o || state !== s) begin
            n_miss++;
            $display("FAIL %s: got cnt=%0h irq=%0b ovr=%0b st=%0d, expected cnt=%0h irq=%0b ovr=%0b st=%0d",
                     nm, count, irq, ovr, state, c, i, o, s);
        end
    endtask

    task automatic drive(input logic l, input logic [63:0] p, input logic m,
                         input logic e, input logic a);
        load = l; period = p; mode = m; en = e; ack = a;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        // ---------------- vector table --------------------------------------
        // l  period  m  e  a   -> count  irq ovr state
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 2'd0); // first edge after reset
        // One-shot, period 5
        add(1'b1, 64'd5, 1'b0, 1'b1, 1'b0, 64'd5, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd4, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd3, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd2, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 2'd2);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 2'd2);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b0, 1'b0, 2'd2);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b0, 1'b0, 2'd2); // ACK with IRQ=0
        // Periodic, period 3, overrun
        add(1'b1, 64'd3, 1'b1, 1'b1, 1'b0, 64'd3, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd2, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd3, 1'b1, 1'b0, 2'd1); // edge 3
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd1, 1'b1, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd3, 1'b1, 1'b1, 2'd1); // edge 6 overrun
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd2, 1'b0, 1'b0, 2'd1); // ACK
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd3, 1'b1, 1'b0, 2'd1); // edge 9
        // ACK colliding with expiry
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd1, 1'b1, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd3, 1'b1, 1'b0, 2'd1);
        // LOAD colliding with expiry: expiry discarded, IRQ kept
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd1, 1'b1, 1'b0, 2'd1);
        add(1'b1, 64'd7, 1'b1, 1'b1, 1'b0, 64'd7, 1'b1, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd6, 1'b0, 1'b0, 2'd1);
        // Enable gating, period 4
        add(1'b1, 64'd4, 1'b0, 1'b1, 1'b0, 64'd4, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd3, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd2, 1'b0, 1'b0, 2'd1);
        for (int k = 0; k < 10; k++)
            add(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 2'd2);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b0, 1'b0, 2'd2);
        // LOAD while ENABLE low
        add(1'b1, 64'd2, 1'b1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0, 2'd1);
        // Stop via zero period
        add(1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b0, 1'b0, 2'd0);
        // Period 1 periodic: expiry every enabled cycle
        add(1'b1, 64'd1, 1'b1, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd1, 1'b1, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd1, 1'b1, 1'b1, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0, 2'd1);
        // Full-width period
        add(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2'd1);
        add(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 2'd1);

        // ---------------- reset state -----------------------------------------
        #12;
        chk("reset_state", 64'd0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- table application ----------------------------------
        for (int n = 0; n < vq.size(); n++) begin
            @(negedge clk);
            drive(vq[n].l, vq[n].p, vq[n].m, vq[n].e, vq[n].a);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", n), vq[n].c, vq[n].i, vq[n].o, vq[n].s);
        end

        // ---------------- asynchronous reset mid-RUN -------------------------
        @(negedge clk);
        drive(1'b1, 64'd6, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_pre_load", 64'd6, 1'b1, 1'b0, 2'd1);
        drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_pre_dec", 64'd5, 1'b1, 1'b0, 2'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", 64'd0, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        chk("rst_held", 64'd0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_idle%0d", k), 64'd0, 1'b0, 1'b0, 2'd0);
        end
        @(negedge clk);
        drive(1'b1, 64'd2, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("post_rst_load", 64'd2, 1'b0, 1'b0, 2'd1);
        drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("post_rst_dec", 64'd1, 1'b0, 1'b0, 2'd1);
        @(posedge clk);
        #1;
        chk("post_rst_expire", 64'd0, 1'b1, 1'b0, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/timer_alarm.md
TIMER_ALARM -- requirements
Module: timer_alarm

Interface
REQ-001 SHALL have parameter DATA_W, default 32, half-width of the count and period (full width 2*DATA_W).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port ALARM_ENABLE  input  1  count-down enable; low freezes count and state.
REQ-005 SHALL have port ALARM_MODE  input  1  0 = one-shot, 1 = periodic; captured on load.
REQ-006 SHALL have port ALARM_LOAD  input  1  single-cycle load/restart strobe.
REQ-007 SHALL have port ALARM_PERIOD  input  2*DATA_W  period in enabled cycles; captured on load.
REQ-008 SHALL have port ALARM_IRQ_ACK  input  1  single-cycle acknowledge; clears IRQ and OVERRUN.
REQ-009 SHALL have port ALARM_IRQ  output  1  sticky expiry interrupt, registered.
REQ-010 SHALL have port ALARM_OVERRUN  output  1  sticky flag: expiry occurred while IRQ was still pending.
REQ-011 SHALL have port ALARM_COUNT  output  2*DATA_W  current remaining count, registered.
REQ-012 SHALL have port ALARM_STATE  output  2  FSM state: 0 IDLE, 1 RUN, 2 EXPIRED.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and EXPIRED; the encoding 3 SHALL never be reached.
REQ-014 SHALL, on a LOAD cycle with PERIOD != 0, set count to PERIOD, latch PERIOD and MODE, and enter RUN from any state.
REQ-015 SHALL, on a LOAD cycle with PERIOD == 0, set count to 0 and enter IDLE (stop); IRQ and OVERRUN unaffected.
REQ-016 SHALL, in RUN with ENABLE high and count > 1 and no LOAD, decrement count by 1.
REQ-017 SHALL, in RUN with ENABLE high and count == 1 and no LOAD, generate an expiry event.
REQ-018 SHALL, on expiry in periodic mode, reload count from the latched period and stay in RUN.
REQ-019 SHALL, on expiry in one-shot mode, set count to 0 and enter EXPIRED.
REQ-020 SHALL place the IRQ assertion exactly PERIOD enabled cycles after the LOAD edge; with ENABLE held high, IRQ reads 1 after the PERIOD-th rising edge following the load edge.
REQ-021 SHALL hold count and state unchanged while ENABLE is low; LOAD SHALL still act when ENABLE is low.
REQ-022 SHALL give LOAD priority over a same-cycle expiry; that expiry is discarded (no IRQ, no OVERRUN).
REQ-023 SHALL, in IDLE and EXPIRED, hold count; only LOAD leaves these states.
REQ-024 SHALL set IRQ on expiry and keep it set until an ACK cycle with no same-cycle expiry.
REQ-025 SHALL, with ACK and expiry in the same cycle, leave IRQ at 1 and OVERRUN at 0.
REQ-026 SHALL set OVERRUN on expiry when IRQ is already 1 and ACK is low; ACK SHALL clear it.
REQ-027 SHALL ignore ACK when IRQ is 0, with no side effects.
REQ-028 SHALL not let LOAD clear IRQ or OVERRUN.
REQ-029 SHALL treat PERIOD == 1 periodic as an expiry on every enabled cycle.
REQ-030 SHALL apply no wrap-around: count never decrements below 1 in RUN.

Reset
REQ-031 SHALL, while rst is low, asynchronously force count 0, latched period 0, latched mode 0, IRQ 0, OVERRUN 0, and state IDLE.
REQ-032 SHALL, on reset asserted mid-RUN, abort the operation; after release the block stays IDLE until the next LOAD.
REQ-033 SHALL, after reset release, treat the first rising edge as normal operation with no spurious IRQ.

Verification
REQ-034 One-shot: ENABLE=1, LOAD with PERIOD=5, MODE=0 -> COUNT 5,4,3,2,1; IRQ=1 and STATE=EXPIRED with COUNT=0 after the 5th edge; remains so indefinitely.
REQ-035 Periodic/overrun: PERIOD=3, MODE=1, no ACK -> IRQ after edge 3; OVERRUN=1 after edge 6; ACK -> both 0 next cycle; next IRQ at edge 9.
REQ-036 Enable gating: PERIOD=4, ENABLE low for 10 cycles after the 2nd decrement -> COUNT frozen at 2; IRQ arrives exactly 2 enabled cycles after ENABLE returns high.
REQ-037 Collisions: LOAD PERIOD=7 on the cycle COUNT==1 -> no IRQ, COUNT=7; ACK on the same cycle as a periodic expiry with IRQ=1 -> IRQ stays 1, OVERRUN 0.
REQ-038 Stop/reset: LOAD PERIOD=0 during RUN -> STATE=IDLE, COUNT=0, IRQ unchanged; rst low mid-RUN -> all outputs 0 immediately without a clock edge.
